signed_addsub_chunked: RTL and testbench
========================================

Name: signed_addsub_chunked

Overview:
Parametrised signed two's-complement adder/subtractor with overflow detection, optional saturation and a sticky overflow flag. It computes CHUNK bits per clock and carries between chunks in a register, so wide operands cost no long combinational carry chain. It uses valid/ready handshakes on input and output and sits between operand sources and accumulate/compare logic in the datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 2.
CHUNK, 4, bits processed per cycle; WIDTH % CHUNK must be 0, otherwise elaboration error.
N (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op valid
in_ready  out  1  block can accept; 1 only in IDLE
a  in  WIDTH  signed operand A
b  in  WIDTH  signed operand B
sub  in  1  0: A+B, 1: A-B
sat  in  1  1: saturate result on overflow
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
s  out  WIDTH  result
cout  out  1  carry out of MSB (for subtract, 1 = no borrow)
ov  out  1  signed overflow of this op
ov_sticky  out  1  set by any completed op with ov=1
ov_clr  in  1  clears ov_sticky

Behaviour:
- One clock, clk; reset synchronous, active-high, port rst.
- Reset values: s=0, cout=0, ov=0, out_valid=0, ov_sticky=0, state=IDLE, chunk index=0, carry reg=0. in_ready=1 from the first cycle after the reset edge.
- Reset dominates every other input in any state. Reset mid-CALC or mid-DONE discards the operation and produces no output.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. At an edge with in_valid=1:
  - latch a, b_eff, sat and sign(a); b_eff = sub ? ~b : b.
  - carry reg <= sub; idx <= 0; go to CALC.
  - Otherwise stay in IDLE.
- CALC: in_ready=0, out_valid=0. Each edge adds chunk idx of a, chunk idx of b_eff and the carry reg, writes CHUNK sum bits into the result reg, updates the carry reg, and does idx++.
  - On the edge that processes idx=N-1: capture carry into MSB (c_msb_in) and carry out (c_out).
  - Same edge: cout <= c_out; ov <= c_msb_in ^ c_out; go to DONE; out_valid <= 1.
- Saturation (applied on the same final edge): if sat=1 and ov=1, s <= sign(a) ? 1000...0 : 0111...1. Otherwise s is the raw modulo-2^WIDTH sum. ov reports 1 even when saturated.
- Latency: out_valid is 1 exactly N cycles after the accept edge. Throughput is one op per N+2 cycles minimum.
- DONE: out_valid=1. s, cout and ov are held stable for as long as out_ready=0. At an edge with out_ready=1: out_valid <= 0, go to IDLE. There is no accept in the same cycle.
- s, cout and ov keep their last value while in IDLE; they change only on the final CALC edge.
- ov_sticky:
  - Set on the final CALC edge when ov=1.
  - Cleared at any edge with ov_clr=1.
  - If set and clear occur on the same edge, set wins.
- Inputs a, b, sub and sat are don't-care outside the accept edge. Changing them during CALC has no effect.

Test Plan:
1. WIDTH=16, CHUNK=4: add 0x1234+0x0FF1, out_ready=1 -> out_valid high exactly 4 cycles after accept; s=0x2225, cout=0, ov=0; in_ready back to 1 one cycle after output handshake.
2. Add 0x7FFF+0x0001 with sat=0 -> s=0x8000, ov=1, cout=0, ov_sticky=1. Same op with sat=1 -> s=0x7FFF, ov=1.
3. Subtract 0x8000-0x0001 with sat=0 -> s=0x7FFF, ov=1, cout=1. Same op with sat=1 -> s=0x8000, ov=1.
4. Add 0xFFFF+0x0001 -> s=0x0000, cout=1, ov=0. Subtract 0x0005-0x0005 -> s=0, cout=1, ov=0. ov_sticky stays 0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> s/cout/ov stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE. Separately, ov_clr=1 on the same edge as an overflowing completion -> ov_sticky=1.
6. Assert rst for one cycle after 2 of 4 chunks are computed -> next cycle out_valid=0, in_ready=1, ov_sticky=0, s=0. A fresh op then completes correctly.

Source files
------------

// File: rtl/signed_addsub_chunked.sv
// Signed adder/subtractor that ripples CHUNK bits per cycle through a registered
// carry, with overflow detection, optional saturation and a sticky overflow flag.
module signed_addsub_chunked #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ov,
  output logic             ov_sticky,
  input  logic             ov_clr
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW   = CHUNK + 1;

  if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("signed_addsub_chunked: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;
  logic              sat_q;
  logic              sign_a_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx;

  logic              accept_c;
  logic              last_c;
  logic [CHUNK-1:0]  chunk_a_c;
  logic [CHUNK-1:0]  chunk_b_c;
  logic [CW-1:0]     chunk_sum_c;
  logic [WIDTH-1:0]  raw_c;
  logic [WIDTH-1:0]  sat_val_c;
  logic              ov_c;

  // One chunk of the ripple add, plus the full-width result on the final chunk
  always_comb begin
    accept_c    = (state == IDLE) && in_valid;
    last_c      = (state == CALC) && (idx == IDXW'(N - 1));
    chunk_a_c   = a_q[idx*CHUNK +: CHUNK];
    chunk_b_c   = b_q[idx*CHUNK +: CHUNK];
    chunk_sum_c = {1'b0, chunk_a_c} + {1'b0, chunk_b_c} + CW'(carry_q);
    raw_c       = res_q;
    raw_c[WIDTH-1 -: CHUNK] = chunk_sum_c[CHUNK-1:0];
    // Same-sign operands giving a different-sign sum == carry-in(MSB) xor carry-out
    ov_c        = (sign_a_q == b_q[WIDTH-1]) && (chunk_sum_c[CHUNK-1] != sign_a_q);
    sat_val_c   = sign_a_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_c)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sat_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      carry_q   <= 1'b0;
      idx       <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ov        <= 1'b0;
      ov_sticky <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q      <= a;
        b_q      <= sub ? ~b : b;
        sat_q    <= sat;
        sign_a_q <= a[WIDTH-1];
        carry_q  <= sub;
        idx      <= '0;
      end else if (state == CALC) begin
        res_q[idx*CHUNK +: CHUNK] <= chunk_sum_c[CHUNK-1:0];
        carry_q <= chunk_sum_c[CHUNK];
        idx     <= idx + IDXW'(1);
        if (last_c) begin
          s    <= (sat_q && ov_c) ? sat_val_c : raw_c;
          cout <= chunk_sum_c[CHUNK];
          ov   <= ov_c;
        end
      end
      // A new overflow outranks a clear arriving on the same edge
      if (last_c && ov_c) begin
        ov_sticky <= 1'b1;
      end else if (ov_clr) begin
        ov_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_signed_addsub_chunked.sv
// Scoreboard bench for signed_addsub_chunked: directed ops push expected results,
// a negedge monitor checks every presented output, latency and state snapshots.
module tb_signed_addsub_chunked;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov;
  } exp_t;

  typedef struct packed {
    logic             full;
    logic             ir;
    logic             ovld;
    logic             stk;
    logic [WIDTH-1:0] s;
  } snap_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ov;
  logic             ov_sticky;
  logic             ov_clr;

  signed_addsub_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ov        (ov),
    .ov_sticky (ov_sticky),
    .ov_clr    (ov_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  q[$];
  snap_t sq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  logic  ovld_prev = 1'b0;
  logic  hs_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record the cycle of each accepted op for the latency check
  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) acc_cyc = cyc;
  end

  // Monitor: compares presented outputs to the scoreboard and snapshot requests
  always @(negedge clk) begin
    if (hs_prev) begin
      chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    end
    hs_prev = 1'b0;
    if (!rst && out_valid === 1'b1) begin
      if (ovld_prev !== 1'b1) chk("latency", 32'(cyc - acc_cyc), 32'(N));
      chk("in_ready_in_done", 32'(in_ready), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        chk("s", 32'(s), 32'(q[0].s));
        chk("cout", 32'(cout), 32'(q[0].cout));
        chk("ov", 32'(ov), 32'(q[0].ov));
        if (out_ready) begin
          void'(q.pop_front());
          hs_prev = 1'b1;
        end
      end
    end
    ovld_prev = out_valid;
    if (sq.size() > 0) begin
      chk("ov_sticky", 32'(ov_sticky), 32'(sq[0].stk));
      if (sq[0].full) begin
        chk("snap_in_ready", 32'(in_ready), 32'(sq[0].ir));
        chk("snap_out_valid", 32'(out_valid), 32'(sq[0].ovld));
        chk("snap_s", 32'(s), 32'(sq[0].s));
        chk("snap_cout", 32'(cout), 32'd0);
        chk("snap_ov", 32'(ov), 32'd0);
      end
      void'(sq.pop_front());
    end
  end

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic sb, input logic st,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n;
    e.s = es; e.cout = ec; e.ov = eo;
    q.push_back(e);
    a = av; b = bv; sub = sb; sat = st; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      $display("FAIL accept_timeout in_ready=%0b", in_ready);
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    sub = 1'($urandom); sat = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout pending=%0d", q.size());
      $fatal(1, "drain timeout");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 100);
    if (out_valid !== 1'b1) begin
      $display("FAIL out_valid_timeout out_valid=%0b", out_valid);
      $fatal(1, "out_valid timeout");
    end
  endtask

  task automatic snap(input logic full, input logic ir, input logic ovld,
                      input logic stk, input logic [WIDTH-1:0] sv);
    snap_t e;
    e.full = full; e.ir = ir; e.ovld = ovld; e.stk = stk; e.s = sv;
    sq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1; ov_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    snap(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Plain add, latency and handshake return
    send(16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0);
    drain();
    snap(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Positive overflow, raw then saturated
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();
    snap(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);

    // Negative overflow on subtract, raw then saturated
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
    send(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    drain();

    ov_clr = 1'b1;
    @(posedge clk);
    #1 ov_clr = 1'b0;
    snap(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Wraparound carry without signed overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    drain();
    snap(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Backpressure: result held, in_valid pulses ignored
    out_ready = 1'b0;
    send(16'h4000, 16'h1000, 1'b1, 1'b0, 16'h3000, 1'b1, 1'b0);
    wait_out_valid();
    repeat (3) begin
      @(posedge clk);
      #1 in_valid = ~in_valid; a = WIDTH'($urandom);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Clear held across an overflowing completion: the set wins
    ov_clr = 1'b1;
    send(16'h9000, 16'h9000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
    wait_out_valid();
    ov_clr = 1'b0;
    @(posedge clk);
    #1;
    snap(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    drain();

    // Reset after two of four chunks discards the op
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    snap(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    send(16'h0123, 16'h0456, 1'b1, 1'b0, 16'hFCCD, 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
